seq_mult_8bit: RTL and testbench



---
 rtl/seq_mult_8bit_pkg.sv | 15 +
 rtl/RCA_8Bit_Adder.sv | 21 ++
 rtl/seq_mult_8bit.sv | 108 ++++++++++
 tb/tb_seq_mult_8bit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_8bit_pkg.sv
// Shared constants and state encoding for the 8x8 sequential multiplier.
package seq_mult_8bit_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned CNT_W  = 3;

    // 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/RCA_8Bit_Adder.sv
// 8-bit ripple-carry adder: s + (c << 8) = a + b + c0.
module RCA_8Bit_Adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c0,
    output logic [7:0] s,
    output logic       c
);

    logic [8:0] carry;

    assign carry[0] = c0;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c = carry[8];

endmodule

// File: rtl/seq_mult_8bit.sv
// Unsigned 8x8 shift-and-add multiplier, one add per clock, 16-bit product with done pulse.
// Optional ovf output (product[15:8] != 0) enabled by defining SEQ_MULT_8BIT_OVF_EN.
module seq_mult_8bit
    import seq_mult_8bit_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        ready,
    output logic        busy,
    output logic        done,
`ifdef SEQ_MULT_8BIT_OVF_EN
    output logic        ovf,
`endif
    output logic [15:0] product
);

    // The datapath is built around a single 8-bit adder instance.
    if (N != OP_W) begin : g_bad_width
        $error("seq_mult_8bit: N must be 8");
    end

    state_t                 state;
    logic [OP_W-1:0]        m_reg;
    logic [OP_W-1:0]        acc;
    logic [OP_W-1:0]        q;
    logic [CNT_W-1:0]       count;

    logic [OP_W-1:0]        addend;
    logic [OP_W-1:0]        sum;
    logic                   carry;
    logic [OP_W-1:0]        acc_nxt;
    logic [OP_W-1:0]        q_nxt;

    assign addend = q[0] ? m_reg : '0;

    RCA_8Bit_Adder u_adder (
        .a  (acc),
        .b  (addend),
        .c0 (1'b0),
        .s  (sum),
        .c  (carry)
    );

    // Right shift of {carry, sum, q}: carry enters acc[7], sum[0] enters q[7].
    assign acc_nxt = {carry, sum[OP_W-1:1]};
    assign q_nxt   = {sum[0], q[OP_W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            m_reg   <= '0;
            acc     <= '0;
            q       <= '0;
            count   <= '0;
`ifdef SEQ_MULT_8BIT_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m_reg <= a;
                        q     <= b;
                        acc   <= '0;
                        count <= '0;
                        state <= ST_RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_nxt;
                    q     <= q_nxt;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(N - 1)) begin
                        product <= {acc_nxt, q_nxt};
`ifdef SEQ_MULT_8BIT_OVF_EN
                        ovf     <= (acc_nxt != '0);
`endif
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_8bit.sv
// Directed self-checking bench for seq_mult_8bit.
module tb_seq_mult_8bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;
`ifdef SEQ_MULT_8BIT_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] last_prod;

    logic [7:0]  vec_a   [0:5];
    logic [7:0]  vec_b   [0:5];
    logic [15:0] vec_exp [0:5];

    always #5 clk = ~clk;

    seq_mult_8bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
`ifdef SEQ_MULT_8BIT_OVF_EN
        .ovf     (ovf),
`endif
        .product (product)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (product !== 16'd0) begin errors++; $display("FAIL reset_product got %h want 0000", product); end
`ifdef SEQ_MULT_8BIT_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
        rst = 1'b0;
        last_prod = 16'd0;
    endtask

    // Isolated operations; operands are scrambled after the accepting edge.
    task automatic test_products();
        int done_cyc;
        int n_done;
        logic [15:0] prod_at_done;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a = vec_a[k]; b = vec_b[k]; start = 1'b1;
            done_cyc = -1; n_done = 0; prod_at_done = 16'hxxxx;
            for (int i = 1; i <= 11; i++) begin
                @(negedge clk);
                if (i == 1) begin
                    start = 1'b0; a = 8'hA5; b = 8'h5A;
                    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin
                        errors++; $display("FAIL prod%0d_run_flags busy=%b ready=%b want busy=1 ready=0", k, busy, ready);
                    end
                end
                if (i == 5) begin
                    checks++; if (product !== last_prod) begin
                        errors++; $display("FAIL prod%0d_hold got %h want %h", k, product, last_prod);
                    end
                end
                if (done === 1'b1) begin
                    n_done++;
                    if (done_cyc < 0) begin done_cyc = i; prod_at_done = product; end
                end
                if (i == 10) begin
                    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL prod%0d_ready_t10 got %b want 1", k, ready); end
                end
            end
            checks++; if (done_cyc != 9) begin errors++; $display("FAIL prod%0d_latency got %0d want 9", k, done_cyc); end
            checks++; if (n_done != 1) begin errors++; $display("FAIL prod%0d_done_count got %0d want 1", k, n_done); end
            checks++; if (prod_at_done !== vec_exp[k]) begin
                errors++; $display("FAIL prod%0d_value got %h want %h", k, prod_at_done, vec_exp[k]);
            end
`ifdef SEQ_MULT_8BIT_OVF_EN
            checks++; if (ovf !== (vec_exp[k][15:8] != 8'd0)) begin
                errors++; $display("FAIL prod%0d_ovf got %b want %b", k, ovf, (vec_exp[k][15:8] != 8'd0));
            end
`endif
            last_prod = vec_exp[k];
        end
    endtask

    // A second start during RUN must be ignored.
    task automatic test_restart();
        int done_cyc;
        int n_done;
        logic [15:0] prod_at_done;
        @(negedge clk);
        a = 8'd12; b = 8'd11; start = 1'b1;
        done_cyc = -1; n_done = 0; prod_at_done = 16'hxxxx;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 4) begin start = 1'b1; a = 8'd3; b = 8'd3; end
            if (i == 5) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin done_cyc = i; prod_at_done = product; end
            end
        end
        checks++; if (done_cyc != 9) begin errors++; $display("FAIL restart_latency got %0d want 9", done_cyc); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL restart_done_count got %0d want 1", n_done); end
        checks++; if (prod_at_done !== 16'd132) begin errors++; $display("FAIL restart_value got %h want %h", prod_at_done, 16'd132); end
        checks++; if (product !== 16'd132) begin errors++; $display("FAIL restart_hold got %h want %h", product, 16'd132); end
        last_prod = 16'd132;
    endtask

    // Reset mid-run discards the operation, then a fresh multiply works.
    task automatic test_reset_mid();
        int done_cyc;
        int n_done;
        logic [15:0] prod_at_done;
        @(negedge clk);
        a = 8'd50; b = 8'd50; start = 1'b1;
        n_done = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 5) rst = 1'b1;
            if (i == 6) begin
                rst = 1'b0;
                checks++; if (ready !== 1'b1 || busy !== 1'b0) begin
                    errors++; $display("FAIL rstmid_flags ready=%b busy=%b want ready=1 busy=0", ready, busy);
                end
                checks++; if (product !== 16'd0) begin errors++; $display("FAIL rstmid_product got %h want 0000", product); end
            end
            if (done === 1'b1) n_done++;
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", n_done); end
        last_prod = 16'd0;

        @(negedge clk);
        a = 8'd7; b = 8'd6; start = 1'b1;
        done_cyc = -1; n_done = 0; prod_at_done = 16'hxxxx;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin done_cyc = i; prod_at_done = product; end
            end
        end
        checks++; if (done_cyc != 9 || n_done != 1) begin
            errors++; $display("FAIL rstmid_fresh_latency got cyc=%0d n=%0d want cyc=9 n=1", done_cyc, n_done);
        end
        checks++; if (prod_at_done !== 16'd42) begin errors++; $display("FAIL rstmid_fresh_value got %h want %h", prod_at_done, 16'd42); end
        last_prod = 16'd42;
    endtask

    // start held high: one product every 10 cycles.
    task automatic test_back_to_back();
        int n_done;
        int first_cyc;
        int prev_cyc;
        int bad_gap;
        int bad_val;
        @(negedge clk);
        a = 8'd2; b = 8'd3; start = 1'b1;
        n_done = 0; first_cyc = -1; prev_cyc = -1; bad_gap = 0; bad_val = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (first_cyc < 0) first_cyc = i;
                if (prev_cyc >= 0 && (i - prev_cyc) != 10) bad_gap++;
                if (product !== 16'd6) bad_val++;
                prev_cyc = i;
            end
        end
        start = 1'b0;
        checks++; if (n_done != 4) begin errors++; $display("FAIL b2b_done_count got %0d want 4", n_done); end
        checks++; if (first_cyc != 9) begin errors++; $display("FAIL b2b_first_latency got %0d want 9", first_cyc); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_spacing bad_gaps=%0d want 0", bad_gap); end
        checks++; if (bad_val != 0) begin errors++; $display("FAIL b2b_value bad_products=%0d want 0", bad_val); end
        repeat (2) @(negedge clk);
        last_prod = 16'd6;
    endtask

    initial begin
        vec_a[0] = 8'd10;  vec_b[0] = 8'd15;  vec_exp[0] = 16'd150;
        vec_a[1] = 8'd255; vec_b[1] = 8'd255; vec_exp[1] = 16'hFE01;
        vec_a[2] = 8'd100; vec_b[2] = 8'd105; vec_exp[2] = 16'h2904;
        vec_a[3] = 8'd0;   vec_b[3] = 8'd200; vec_exp[3] = 16'd0;
        vec_a[4] = 8'd200; vec_b[4] = 8'd0;   vec_exp[4] = 16'd0;
        vec_a[5] = 8'd1;   vec_b[5] = 8'd255; vec_exp[5] = 16'd255;

        test_reset();
        test_products();
        test_restart();
        test_reset_mid();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
